johnson_decoder: RTL and testbench

Receive-side counterpart of the Johnson-counter phase generator. Samples a WIDTH-bit Johnson code from a remote ring-counter stage and decodes it to a binary phase index. Checks every code for legality and every transition for a correct +1 step. Runs a HUNT/SYNC/LOCKED tracker so downstream sample-enable logic can trust the phase only while locked.

---
 rtl/johnson_pkg.sv | 13 +
 rtl/johnson_code_check.sv | 42 ++++
 rtl/johnson_decoder.sv | 154 +++++++++++++++
 tb/tb_johnson_decoder.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/johnson_pkg.sv
// rtl/johnson_pkg.sv - shared types and constants for the Johnson-code decoder
package johnson_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam int ERR_CNT_W = 8;
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 8'hFF;

endpackage

// File: rtl/johnson_code_check.sv
// rtl/johnson_code_check.sv - combinational Johnson code legality check and phase decode
module johnson_code_check
    import johnson_pkg::*;
#(
    parameter  int WIDTH = 4,
    localparam int PW    = $clog2(2 * WIDTH)
) (
    input  logic [WIDTH-1:0] jc_in,
    output logic             legal,
    output logic [PW-1:0]    dec_phase
);

    localparam int EW = $clog2(WIDTH) + 1;
    localparam logic [PW:0] TWO_W = (PW + 1)'(2 * WIDTH);

    logic [EW-1:0] edges;
    logic [PW-1:0] pop;

    // A legal Johnson word is a single run of ones and a single run of zeros.
    always_comb begin
        edges = '0;
        for (int i = 1; i < WIDTH; i++) begin
            if (jc_in[i] != jc_in[i-1]) begin
                edges = edges + EW'(1);
            end
        end
        legal = (edges <= EW'(1));
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop = pop + PW'(jc_in[i]);
        end
        if (jc_in[WIDTH-1] || (jc_in == '0)) begin
            dec_phase = pop;
        end else begin
            dec_phase = PW'(TWO_W - {1'b0, pop});
        end
    end

endmodule

// File: rtl/johnson_decoder.sv
// rtl/johnson_decoder.sv - Johnson code receiver with lock tracker; optional JOHNSON_DEC_FLYWHEEL_EN
module johnson_decoder
    import johnson_pkg::*;
#(
    parameter  int WIDTH    = 4,
    parameter  int LOCK_CNT = 2,
    localparam int PW       = $clog2(2 * WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     jc_in,
    input  logic                 jc_valid,
    output logic [PW-1:0]        phase,
    output logic                 phase_valid,
    output logic                 code_err,
    output logic                 step_err,
    output logic                 locked,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int CW = $clog2(LOCK_CNT + 1);
    localparam logic [PW-1:0] LAST_PH = PW'(2 * WIDTH - 1);

    state_t               state, state_nx;
    logic [CW-1:0]        step_cnt, cnt_nx;
    logic                 legal;
    logic [PW-1:0]        dec_phase, exp_phase;
    logic                 step_ok;
    logic [PW-1:0]        phase_nx;
    logic                 pv_nx, ce_nx, se_nx;
    logic [ERR_CNT_W-1:0] err_cnt_nx;
`ifdef JOHNSON_DEC_FLYWHEEL_EN
    logic                 miss, miss_nx;
`endif

    johnson_code_check #(.WIDTH(WIDTH)) u_check (
        .jc_in     (jc_in),
        .legal     (legal),
        .dec_phase (dec_phase)
    );

    assign exp_phase = (phase == LAST_PH) ? '0 : phase + PW'(1);
    assign step_ok   = legal && (dec_phase == exp_phase);
    assign locked    = (state == LOCKED);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= HUNT;
            step_cnt    <= '0;
            phase       <= '0;
            phase_valid <= 1'b0;
            code_err    <= 1'b0;
            step_err    <= 1'b0;
            err_cnt     <= '0;
`ifdef JOHNSON_DEC_FLYWHEEL_EN
            miss        <= 1'b0;
`endif
        end else begin
            state       <= state_nx;
            step_cnt    <= cnt_nx;
            phase       <= phase_nx;
            phase_valid <= pv_nx;
            code_err    <= ce_nx;
            step_err    <= se_nx;
            err_cnt     <= err_cnt_nx;
`ifdef JOHNSON_DEC_FLYWHEEL_EN
            miss        <= miss_nx;
`endif
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = step_cnt;
`ifdef JOHNSON_DEC_FLYWHEEL_EN
        miss_nx  = miss;
`endif
        if (jc_valid) begin
            case (state)
                HUNT: begin
                    if (legal) begin
                        state_nx = SYNC;
                        cnt_nx   = '0;
                    end
                end
                SYNC: begin
                    if (!legal) begin
                        state_nx = HUNT;
                        cnt_nx   = '0;
                    end else if (step_ok) begin
                        cnt_nx = step_cnt + CW'(1);
                        if (cnt_nx == CW'(LOCK_CNT)) begin
                            state_nx = LOCKED;
                        end
                    end else begin
                        cnt_nx = '0;
                    end
                end
                LOCKED: begin
`ifdef JOHNSON_DEC_FLYWHEEL_EN
                    // One bad sample is ridden through; a second in a row drops lock.
                    if (step_ok) begin
                        miss_nx = 1'b0;
                    end else if (!miss) begin
                        miss_nx = 1'b1;
                    end else begin
                        miss_nx  = 1'b0;
                        state_nx = HUNT;
                        cnt_nx   = '0;
                    end
`else
                    if (!step_ok) begin
                        state_nx = HUNT;
                        cnt_nx   = '0;
                    end
`endif
                end
                default: begin
                    state_nx = HUNT;
                    cnt_nx   = '0;
                end
            endcase
        end
    end

    always_comb begin
        phase_nx   = phase;
        pv_nx      = 1'b0;
        ce_nx      = 1'b0;
        se_nx      = 1'b0;
        err_cnt_nx = err_cnt;
        if (jc_valid) begin
            if (!legal) begin
                ce_nx = 1'b1;
            end else if ((state != HUNT) && !step_ok) begin
                se_nx = 1'b1;
            end
            if (legal) begin
                phase_nx = dec_phase;
                pv_nx    = 1'b1;
            end
`ifdef JOHNSON_DEC_FLYWHEEL_EN
            if ((state == LOCKED) && !step_ok && !miss) begin
                phase_nx = exp_phase;
                pv_nx    = 1'b1;
            end
`endif
            if ((ce_nx || se_nx) && (err_cnt != ERR_CNT_MAX)) begin
                err_cnt_nx = err_cnt + ERR_CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_johnson_decoder.sv
// tb/tb_johnson_decoder.sv - self-checking bench for johnson_decoder against a table-driven model
module tb_johnson_decoder;

    localparam int W  = 4;
    localparam int L  = 2;
    localparam int N  = 2 * W;
    localparam int PW = $clog2(2 * W);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  jc_in = '0;
    logic          jc_valid = 1'b0;
    logic [PW-1:0] phase;
    logic          phase_valid, code_err, step_err, locked;
    logic [7:0]    err_cnt;

    johnson_decoder #(.WIDTH(W), .LOCK_CNT(L)) dut (
        .clk         (clk),
        .rst         (rst),
        .jc_in       (jc_in),
        .jc_valid    (jc_valid),
        .phase       (phase),
        .phase_valid (phase_valid),
        .code_err    (code_err),
        .step_err    (step_err),
        .locked      (locked),
        .err_cnt     (err_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] tbl [N];
    int m_state, m_cnt, m_phase, m_err;
    bit m_pv, m_ce, m_se, m_miss;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int lookup(input logic [W-1:0] code);
        for (int k = 0; k < N; k++) if (tbl[k] == code) return k;
        return -1;
    endfunction

    task automatic model_reset();
        m_state = 0; m_cnt = 0; m_phase = 0; m_err = 0;
        m_pv = 0; m_ce = 0; m_se = 0; m_miss = 0;
    endtask

    task automatic model_apply(input bit v, input logic [W-1:0] code);
        int idx;
        bit good;
        m_pv = 0; m_ce = 0; m_se = 0;
        if (!v) return;
        idx  = lookup(code);
        good = (idx >= 0) && (idx == (m_phase + 1) % N);
        case (m_state)
            0: if (idx < 0) m_ce = 1;
               else begin m_phase = idx; m_pv = 1; m_state = 1; m_cnt = 0; end
            1: if (idx < 0) begin m_ce = 1; m_state = 0; end
               else begin
                   m_phase = idx; m_pv = 1;
                   if (good) begin m_cnt++; if (m_cnt == L) m_state = 2; end
                   else begin m_se = 1; m_cnt = 0; end
               end
            default: if (good) begin m_phase = idx; m_pv = 1; m_miss = 0; end
               else begin
                   if (idx < 0) m_ce = 1; else m_se = 1;
`ifdef JOHNSON_DEC_FLYWHEEL_EN
                   if (!m_miss) begin
                       m_miss = 1; m_phase = (m_phase + 1) % N; m_pv = 1;
                   end else begin
                       m_miss = 0; m_state = 0;
                       if (idx >= 0) begin m_phase = idx; m_pv = 1; end
                   end
`else
                   m_state = 0;
                   if (idx >= 0) begin m_phase = idx; m_pv = 1; end
`endif
               end
        endcase
        if ((m_ce || m_se) && m_err < 255) m_err++;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".phase"},       32'(phase),       32'(m_phase));
        chk({tag, ".phase_valid"}, 32'(phase_valid), 32'(m_pv));
        chk({tag, ".code_err"},    32'(code_err),    32'(m_ce));
        chk({tag, ".step_err"},    32'(step_err),    32'(m_se));
        chk({tag, ".locked"},      32'(locked),      32'(m_state == 2));
        chk({tag, ".err_cnt"},     32'(err_cnt),     32'(m_err));
    endtask

    task automatic step(input bit v, input logic [W-1:0] code, input string tag);
        jc_valid = v;
        jc_in    = code;
        @(posedge clk);
        #1;
        model_apply(v, code);
        check_all(tag);
    endtask

    initial begin
        logic [W-1:0] c;
        int r;
        bit v;

        c = '0;
        for (int k = 0; k < N; k++) begin
            tbl[k] = c;
            c = {~c[0], c[W-1:1]};
        end
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        // full sequence with wrap back to 0000
        for (int k = 0; k <= N; k++) step(1'b1, tbl[k % N], "seq");
        step(1'b1, tbl[1], "seq");
        step(1'b1, tbl[2], "seq");
        step(1'b1, 4'b1010, "illegal_locked");

        // relock, then a skipped code (1100 -> 1111)
        step(1'b1, tbl[3], "relock");
        step(1'b1, tbl[4], "relock");
        step(1'b1, tbl[5], "relock");
        step(1'b1, tbl[6], "relock");
        step(1'b1, tbl[7], "relock");
        step(1'b1, tbl[0], "relock");
        step(1'b1, tbl[1], "relock");
        step(1'b1, tbl[2], "relock");
        step(1'b1, tbl[4], "misstep");
        step(1'b1, tbl[5], "recover");
        step(1'b1, tbl[6], "recover");
        step(1'b1, tbl[7], "recover");
        step(1'b1, tbl[0], "recover");

        // idle gap while locked
        step(1'b1, tbl[1], "gap");
        step(1'b1, tbl[2], "gap");
        step(1'b1, tbl[3], "gap");
        for (int k = 0; k < 3; k++) step(1'b0, 4'b0101, "gap_idle");
        step(1'b1, tbl[4], "gap_resume");

        // asynchronous reset between edges
        jc_valid = 1'b1;
        jc_in    = tbl[5];
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, tbl[0], "post_rst");

        // randomized traffic
        for (int k = 0; k < 600; k++) begin
            r = $urandom_range(0, 9);
            v = ($urandom_range(0, 7) != 0);
            if (r < 6)      c = tbl[(m_phase + 1) % N];
            else if (r < 8) c = tbl[$urandom_range(0, N - 1)];
            else            c = W'($urandom);
            step(v, c, "rand");
        end

        // error counter saturation
        for (int k = 0; k < 300; k++) step(1'b1, 4'b0101, "saturate");
        chk("err_cnt_sat", 32'(err_cnt), 32'd255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
